// File: rtl/base_credit_tx.sv
`default_nettype none
// ============================================================================
// Module      : base_credit_tx
// Description : Transmit end of a credit-based link. A 2-entry skid buffer
//               accepts a valid/ready stream; beats are forwarded on a link
//               without back-pressure, one credit spent per beat, credits
//               regained from returned credit pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module base_credit_tx #(
    parameter int WIDTH   = 1,  // data width in bits
    parameter int CREDITS = 4,  // initial/maximum credits, equals far-end buffer depth (>=1)
    parameter int ODELAY  = 1,  // register stages on the forward o_v/o_d path (>=1)
    parameter int CDELAY  = 0   // register stages on the returned credit (>=0)
) (
    input  logic                         clk,
    input  logic                         reset,   // synchronous, active-low
    input  logic                         i_v,
    input  logic [WIDTH-1:0]             i_d,
    output logic                         i_r,
    output logic                         o_v,
    output logic [WIDTH-1:0]             o_d,
    input  logic                         i_c,
    output logic [$clog2(CREDITS+1)-1:0] o_crd,
    output logic                         o_err
);

    localparam int                c_cw      = $clog2(CREDITS + 1);
    localparam logic [c_cw-1:0]   c_cnt_max = c_cw'(CREDITS);
    localparam logic [c_cw-1:0]   c_cnt_one = c_cw'(1);

    // Skid buffer state: entry 0 is always the head of the queue
    logic [1:0]       r_occ_q, w_occ_d;
    logic [WIDTH-1:0] r_buf_q [2];
    logic [WIDTH-1:0] w_buf_d [2];
    logic [1:0]       w_occ_after_send;

    // Credit counter and sticky overflow flag
    logic [c_cw-1:0]  r_cnt_q, w_cnt_d;
    logic             r_err_q, w_err_d;

    // Forward link pipeline
    logic             r_ov_q [ODELAY];
    logic             w_ov_d [ODELAY];
    logic [WIDTH-1:0] r_od_q [ODELAY];
    logic [WIDTH-1:0] w_od_d [ODELAY];

    logic             w_acc;
    logic             w_send;
    logic             w_c_ret;

    // Ready depends only on registered occupancy and reset, never on the link
    assign i_r   = (r_occ_q != 2'd2) & reset;
    assign o_v   = r_ov_q[ODELAY-1];
    assign o_d   = r_od_q[ODELAY-1];
    assign o_crd = r_cnt_q;
    assign o_err = r_err_q;

    // Returned-credit delay line; zero stages means the pulse is counted directly
    generate
        if (CDELAY == 0) begin : g_cret_direct
            assign w_c_ret = i_c;
        end else begin : g_cret_pipe
            logic r_cv_q [CDELAY];
            logic w_cv_d [CDELAY];

            // Shift the credit pulse one stage per cycle
            always_comb begin
                w_cv_d[0] = i_c;
                for (int i = 1; i < CDELAY; i++) begin
                    w_cv_d[i] = r_cv_q[i-1];
                end
            end

            // Credit valid bits are cleared so in-flight credits are discarded on reset
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < CDELAY; i++) begin
                        r_cv_q[i] <= 1'b0;
                    end
                end else begin
                    for (int i = 0; i < CDELAY; i++) begin
                        r_cv_q[i] <= w_cv_d[i];
                    end
                end
            end

            assign w_c_ret = r_cv_q[CDELAY-1];
        end
    endgenerate

    // Handshake, skid-buffer update and credit accounting
    always_comb begin
        w_acc  = i_v & i_r;
        w_send = (r_occ_q != 2'd0) & (r_cnt_q != '0);

        w_occ_d          = r_occ_q + 2'(w_acc) - 2'(w_send);
        w_occ_after_send = r_occ_q - 2'(w_send);

        // Sending pops the head; a new beat lands behind whatever remains
        w_buf_d[0] = r_buf_q[0];
        w_buf_d[1] = r_buf_q[1];
        if (w_send) begin
            w_buf_d[0] = r_buf_q[1];
        end
        if (w_acc) begin
            if (w_occ_after_send == 2'd0) begin
                w_buf_d[0] = i_d;
            end else begin
                w_buf_d[1] = i_d;
            end
        end

        // A credit returned while already full is an error and is not counted
        w_cnt_d = r_cnt_q;
        w_err_d = r_err_q;
        if (w_send && !w_c_ret) begin
            w_cnt_d = r_cnt_q - c_cnt_one;
        end else if (!w_send && w_c_ret) begin
            if (r_cnt_q == c_cnt_max) begin
                w_err_d = 1'b1;
            end else begin
                w_cnt_d = r_cnt_q + c_cnt_one;
            end
        end

        // Head data enters the forward pipeline; valid marks real beats
        w_ov_d[0] = w_send;
        w_od_d[0] = r_buf_q[0];
        for (int i = 1; i < ODELAY; i++) begin
            w_ov_d[i] = r_ov_q[i-1];
            w_od_d[i] = r_od_q[i-1];
        end
    end

    // Control state: occupancy, credits, error and forward valid bits
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_occ_q <= 2'd0;
            r_cnt_q <= c_cnt_max;
            r_err_q <= 1'b0;
            for (int i = 0; i < ODELAY; i++) begin
                r_ov_q[i] <= 1'b0;
            end
        end else begin
            r_occ_q <= w_occ_d;
            r_cnt_q <= w_cnt_d;
            r_err_q <= w_err_d;
            for (int i = 0; i < ODELAY; i++) begin
                r_ov_q[i] <= w_ov_d[i];
            end
        end
    end

    // Data storage is qualified by the valid/occupancy state, so it needs no reset
    always_ff @(posedge clk) begin
        r_buf_q[0] <= w_buf_d[0];
        r_buf_q[1] <= w_buf_d[1];
        for (int i = 0; i < ODELAY; i++) begin
            r_od_q[i] <= w_od_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_base_credit_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_base_credit_tx
// Description : Scoreboard bench for base_credit_tx (WIDTH=8, CREDITS=4,
//               ODELAY=1, CDELAY=0) with directed vectors and a loopback run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_base_credit_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         i_v = 1'b0;
    logic [W-1:0] i_d = '0;
    logic         i_r;
    logic         o_v;
    logic [W-1:0] o_d;
    logic         i_c;
    logic [2:0]   o_crd;
    logic         o_err;

    logic         tb_ic = 1'b0;
    logic         lb_mode = 1'b0;
    logic         lb1, lb2;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           ov_cnt = 0;
    int           ov_first = 0;
    int           ov_last = 0;
    int           stalls = 0;

    logic [W-1:0] sb [$];

    // Hand-computed per-cycle expectations
    int a_ir  [13] = '{1,1,1,1,1,1,0,0,0,0,0,0,0};
    int a_ov  [13] = '{0,0,1,1,1,1,0,0,0,0,0,0,1};
    int a_crd [13] = '{4,4,3,2,1,0,0,0,0,0,0,1,0};
    int c_ov  [8]  = '{0,0,1,1,1,1,1,0};
    int c_crd [8]  = '{4,4,3,2,1,1,0,0};

    always #5 clk = ~clk;

    assign i_c = lb_mode ? lb2 : tb_ic;

    base_credit_tx #(
        .WIDTH   (W),
        .CREDITS (4),
        .ODELAY  (1),
        .CDELAY  (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_d   (i_d),
        .i_r   (i_r),
        .o_v   (o_v),
        .o_d   (o_d),
        .i_c   (i_c),
        .o_crd (o_crd),
        .o_err (o_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Far-end model for loopback: o_v returns as a credit two registers later
    always @(posedge clk) begin
        if (!reset) begin
            lb1 <= 1'b0;
            lb2 <= 1'b0;
        end else begin
            lb1 <= o_v;
            lb2 <= lb1;
        end
    end

    // Monitor: every forward beat must match the oldest expected beat
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (o_v === 1'b1) begin
                if (lb_mode) begin
                    if (ov_cnt == 0) ov_first = cyc;
                    ov_last = cyc;
                    ov_cnt++;
                end
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_o_v: got o_d=%0h, required no beat (t=%0t)", o_d, $time);
                end else begin
                    e = sb.pop_front();
                    if (o_d !== e) begin
                        bad++;
                        $display("FAIL o_d_order: got %0h, required %0h (t=%0t)", o_d, e, $time);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles; returns in the first cycle with reset released
    task automatic do_reset();
        reset = 1'b0;
        i_v   = 1'b0;
        tb_ic = 1'b0;
        #1;
        chk("rst_ir", 32'(i_r), 0);
        step();
        chk("rst_ov", 32'(o_v), 0);
        step();
        reset = 1'b1;
        sb.delete();
        #1;
        chk("post_rst_crd", 32'(o_crd), 4);
        chk("post_rst_err", 32'(o_err), 0);
        chk("post_rst_ir", 32'(i_r), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;

        // Six beats with no credits returned, then one credit, then reset mid-stream
        do_reset();
        for (int c = 0; c < 13; c++) begin
            i_v   = (c < 6);
            i_d   = 8'(8'hA0 + c);
            tb_ic = (c == 10) || (c == 12);
            reset = (c != 12);
            if (c < 6) sb.push_back(8'(8'hA0 + c));
            #1;
            chk($sformatf("A_ir_c%0d", c), 32'(i_r), 32'(a_ir[c]));
            chk($sformatf("A_ov_c%0d", c), 32'(o_v), 32'(a_ov[c]));
            chk($sformatf("A_crd_c%0d", c), 32'(o_crd), 32'(a_crd[c]));
            step();
        end
        reset = 1'b1;
        i_v   = 1'b0;
        tb_ic = 1'b0;
        sb.delete();
        #1;
        chk("E_ov_after_rst", 32'(o_v), 0);
        chk("E_crd_after_rst", 32'(o_crd), 4);
        chk("E_err_after_rst", 32'(o_err), 0);
        chk("E_ir_after_rst", 32'(i_r), 1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("E_ov_idle%0d", c), 32'(o_v), 0);
        end

        // Credit returned while idle and full: sticky error, count held
        do_reset();
        tb_ic = 1'b1;
        #1;
        chk("B_err_c0", 32'(o_err), 0);
        step();
        tb_ic = 1'b0;
        #1;
        chk("B_err_c1", 32'(o_err), 1);
        chk("B_crd_c1", 32'(o_crd), 4);
        for (int c = 2; c < 5; c++) begin
            step();
            chk($sformatf("B_err_c%0d", c), 32'(o_err), 1);
            chk($sformatf("B_crd_c%0d", c), 32'(o_crd), 4);
        end

        // Send and credit return in the same cycle at cnt=1
        do_reset();
        for (int c = 0; c < 8; c++) begin
            i_v   = (c < 5);
            i_d   = 8'(8'hC0 + c);
            tb_ic = (c == 4);
            if (c < 5) sb.push_back(8'(8'hC0 + c));
            #1;
            chk($sformatf("C_ir_c%0d", c), 32'(i_r), 1);
            chk($sformatf("C_ov_c%0d", c), 32'(o_v), 32'(c_ov[c]));
            chk($sformatf("C_crd_c%0d", c), 32'(o_crd), 32'(c_crd[c]));
            step();
        end
        i_v   = 1'b0;
        tb_ic = 1'b0;

        // Loopback at full rate: 100 incrementing beats
        do_reset();
        lb_mode = 1'b1;
        ov_cnt  = 0;
        stalls  = 0;
        for (int k = 0; k < 100; k++) begin
            i_v = 1'b1;
            i_d = 8'(k);
            #1;
            waits = 0;
            while (!i_r && waits < 20) begin
                stalls++;
                step();
                waits++;
            end
            if (!i_r) begin
                chk("D_ir_timeout", 32'(i_r), 1);
            end else begin
                sb.push_back(8'(k));
            end
            step();
        end
        i_v = 1'b0;
        waits = 0;
        while (sb.size() != 0 && waits < 50) begin
            step();
            waits++;
        end
        chk("D_drain", 32'(sb.size()), 0);
        chk("D_stalls", 32'(stalls), 0);
        chk("D_ov_count", 32'(ov_cnt), 100);
        chk("D_ov_span", 32'(ov_last - ov_first + 1), 100);
        chk("D_err", 32'(o_err), 0);
        lb_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
